// File: rtl/neuron_sequencer.sv
// Initiator-side sequencer for a neuron: gathers NUM_INPUTS serial samples into a
// parallel vector, strobes start, waits for done under a watchdog, then presents the result.
module neuron_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_INPUTS     = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] neuron_inputs [NUM_INPUTS],
    output logic                         neuron_start,
    input  logic signed [DATA_WIDTH-1:0] neuron_result,
    input  logic                         neuron_done,
    output logic signed [DATA_WIDTH-1:0] result,
    output logic                         result_valid,
    input  logic                         result_ready,
    output logic                         busy,
    output logic                         timeout_error
);

    localparam int CW = $clog2(NUM_INPUTS);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_INDEX = CW'(NUM_INPUTS - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_START   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_PRESENT = 2'd3
    } state_t;

    state_t                         r_state;
    state_t                         w_state_next;
    logic [CW-1:0]                  r_count;
    logic [CW-1:0]                  w_count_next;
    logic [TW-1:0]                  r_timer;
    logic [TW-1:0]                  w_timer_next;
    logic signed [DATA_WIDTH-1:0]   r_result;
    logic signed [DATA_WIDTH-1:0]   w_result_next;
    logic                           r_timeout_error;
    logic                           w_timeout_error_next;
    logic                           w_accept;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= ST_COLLECT;
            r_count         <= '0;
            r_timer         <= '0;
            r_result        <= '0;
            r_timeout_error <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_count         <= w_count_next;
            r_timer         <= w_timer_next;
            r_result        <= w_result_next;
            r_timeout_error <= w_timeout_error_next;
        end
    end

    always_comb begin
        w_state_next         = r_state;
        w_count_next         = r_count;
        w_timer_next         = r_timer;
        w_result_next        = r_result;
        w_timeout_error_next = r_timeout_error;
        w_accept             = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    if (r_count == LAST_INDEX) begin
                        w_count_next = '0;
                        w_state_next = ST_START;
                    end else begin
                        w_count_next = r_count + CW'(1);
                    end
                end
            end
            ST_START: begin
                w_timer_next = '0;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                w_timer_next = r_timer + TW'(1);
                // A done arriving on the expiry cycle takes priority over the timeout.
                if (neuron_done) begin
                    w_result_next = neuron_result;
                    w_state_next  = ST_PRESENT;
                end else if (r_timer == TIMER_LAST) begin
                    w_result_next        = '0;
                    w_timeout_error_next = 1'b1;
                    w_state_next         = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (result_ready) begin
                    w_state_next = ST_COLLECT;
                end
            end
            default: begin
                w_state_next = ST_COLLECT;
            end
        endcase
    end

    // Entries only change in COLLECT, so the vector is stable from START to the end of PRESENT.
    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_buffer
            logic signed [DATA_WIDTH-1:0] r_entry;
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_entry <= '0;
                end else if (w_accept && (r_count == CW'(gi))) begin
                    r_entry <= in_data;
                end
            end
            assign neuron_inputs[gi] = r_entry;
        end
    endgenerate

    assign in_ready      = (r_state == ST_COLLECT);
    assign neuron_start  = (r_state == ST_START);
    assign result_valid  = (r_state == ST_PRESENT);
    assign busy          = !((r_state == ST_COLLECT) && (r_count == '0));
    assign result        = r_result;
    assign timeout_error = r_timeout_error;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Bench for neuron_sequencer: a behavioural neuron stub on the far side and a dot-product
// model of the expected result built from the samples the bench itself sends.
module tb_neuron_sequencer;

    localparam int DW = 32;
    localparam int NI = 16;
    localparam int TO = 64;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic signed [DW-1:0] in_data = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] neuron_inputs [NI];
    logic                 neuron_start;
    logic signed [DW-1:0] neuron_result = '0;
    logic                 neuron_done = 1'b0;
    logic signed [DW-1:0] result;
    logic                 result_valid;
    logic                 result_ready = 1'b0;
    logic                 busy;
    logic                 timeout_error;

    int checks = 0;
    int errors = 0;

    logic signed [DW-1:0] samp [NI];
    int                   wts  [NI];
    logic signed [DW-1:0] cap  [NI];

    int                   stub_cnt = -1;
    int                   stub_delay = NI + 3;
    bit                   stub_force = 1'b0;
    logic signed [DW-1:0] stub_force_val = '0;
    int                   pulse_req = 0;
    int                   pulse_ack = 0;

    neuron_sequencer #(
        .DATA_WIDTH(DW),
        .NUM_INPUTS(NI),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .neuron_inputs(neuron_inputs),
        .neuron_start(neuron_start),
        .neuron_result(neuron_result),
        .neuron_done(neuron_done),
        .result(result),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .busy(busy),
        .timeout_error(timeout_error)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected neuron output: ReLU of the weighted sum of the samples sent.
    function automatic logic signed [DW-1:0] model_result();
        longint acc = 0;
        for (int i = 0; i < NI; i++) acc += longint'(samp[i]) * longint'(wts[i]);
        return (acc < 0) ? '0 : DW'(acc);
    endfunction

    function automatic logic signed [DW-1:0] stub_compute();
        longint acc = 0;
        for (int i = 0; i < NI; i++) acc += longint'(cap[i]) * longint'(wts[i]);
        return (acc < 0) ? '0 : DW'(acc);
    endfunction

    // Neuron stub: samples inputs one cycle after start, pulses done stub_delay cycles after start.
    always @(negedge clock) begin
        neuron_done = 1'b0;
        if (neuron_start) stub_cnt = 0;
        else if (stub_cnt >= 0) stub_cnt = stub_cnt + 1;
        if (stub_cnt == 1) begin
            for (int i = 0; i < NI; i++) cap[i] = neuron_inputs[i];
        end
        if (stub_cnt > 0 && stub_cnt == stub_delay) begin
            neuron_done   = 1'b1;
            neuron_result = stub_force ? stub_force_val : stub_compute();
            stub_cnt      = -1;
        end
        if (pulse_req != pulse_ack) begin
            neuron_done   = 1'b1;
            neuron_result = 99;
            pulse_ack     = pulse_req;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_vec(input int mode);
        int i = 0;
        int phase = 0;
        int guard = 0;
        bit v;
        while (i < NI && guard < 400) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (phase % 3 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            in_valid = v;
            if (v) in_data = samp[i];
            else   in_data = DW'($urandom);
            check_val("in_ready_collect", longint'(in_ready), 1);
            check_val("busy_collect", longint'(busy), longint'(i != 0));
            if (v && in_ready) i++;
            phase++;
            guard++;
            tick();
        end
        in_valid = 1'b0;
        check_val("start_at_T+1", longint'(neuron_start), 1);
    endtask

    task automatic run_txn(input string name, input int mode, input int bp, input int delay,
                           input bit frc, input logic signed [DW-1:0] fval, input bit exp_to);
        logic signed [DW-1:0] exp;
        int k = 0;
        int extra = 0;
        int mism = 0;
        int exp_lat;
        stub_delay     = delay;
        stub_force     = frc;
        stub_force_val = fval;
        if (delay < 0) begin
            exp     = '0;
            exp_lat = TO + 1;
        end else begin
            exp     = frc ? fval : model_result();
            exp_lat = delay + 1;
        end
        send_vec(mode);
        for (int i = 0; i < NI; i++) if (neuron_inputs[i] !== samp[i]) mism++;
        check_val("inputs_at_start", mism, 0);
        check_val("in_ready_start", longint'(in_ready), 0);
        while (!result_valid && k < 300) begin
            tick();
            k++;
            if (neuron_start) extra++;
        end
        check_val("start_pulses_extra", extra, 0);
        check_val("latency", k, exp_lat);
        check_val("result", longint'(result), longint'(exp));
        check_val("timeout_error", longint'(timeout_error), longint'(exp_to));
        mism = 0;
        for (int i = 0; i < NI; i++) if (neuron_inputs[i] !== samp[i]) mism++;
        check_val("inputs_stable", mism, 0);
        for (int j = 0; j < bp; j++) begin
            tick();
            check_val("bp_result_valid", longint'(result_valid), 1);
            check_val("bp_result", longint'(result), longint'(exp));
            check_val("bp_in_ready", longint'(in_ready), 0);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check_val("in_ready_after_hs", longint'(in_ready), 1);
        check_val("result_valid_after_hs", longint'(result_valid), 0);
        $display("txn %s: result=%0d expected=%0d latency=%0d timeout_error=%0b",
                 name, result, exp, k, timeout_error);
    endtask

    task automatic fill_seq();
        for (int i = 0; i < NI; i++) begin
            samp[i] = DW'(i + 1);
            wts[i]  = 1;
        end
    endtask

    initial begin
        int mism;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        mism = 0;
        for (int i = 0; i < NI; i++) if (neuron_inputs[i] !== '0) mism++;
        check_val("rst_in_ready", longint'(in_ready), 1);
        check_val("rst_busy", longint'(busy), 0);
        check_val("rst_result_valid", longint'(result_valid), 0);
        check_val("rst_neuron_start", longint'(neuron_start), 0);
        check_val("rst_result", longint'(result), 0);
        check_val("rst_timeout", longint'(timeout_error), 0);
        check_val("rst_inputs_zero", mism, 0);
        $display("txn reset: in_ready=%0b busy=%0b", in_ready, busy);

        fill_seq();
        run_txn("seq_b2b", 0, 0, NI + 3, 1'b0, '0, 1'b0);
        run_txn("seq_every3_bp5", 1, 5, NI + 3, 1'b0, '0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < NI; i++) begin
                samp[i] = DW'(int'($urandom_range(0, 2000)) - 1000);
                wts[i]  = int'($urandom_range(0, 6)) - 3;
            end
            run_txn("random", 2, int'($urandom_range(0, 3)), int'($urandom_range(2, 60)),
                    1'b0, '0, 1'b0);
        end

        run_txn("timeout", 0, 0, -1, 1'b0, '0, 1'b1);
        for (int i = 0; i < NI; i++) begin
            samp[i] = -2;
            wts[i]  = 1;
        end
        run_txn("neg_after_timeout", 2, 1, NI + 3, 1'b0, '0, 1'b1);

        // Reset mid-WAIT with a done arriving after the reset has released.
        fill_seq();
        stub_delay = 10;
        stub_force = 1'b0;
        send_vec(0);
        repeat (6) tick();
        check_val("wait_busy", longint'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mism = 0;
        for (int i = 0; i < NI; i++) if (neuron_inputs[i] !== '0) mism++;
        check_val("midrst_in_ready", longint'(in_ready), 1);
        check_val("midrst_busy", longint'(busy), 0);
        check_val("midrst_result", longint'(result), 0);
        check_val("midrst_result_valid", longint'(result_valid), 0);
        check_val("midrst_start", longint'(neuron_start), 0);
        check_val("midrst_timeout", longint'(timeout_error), 0);
        check_val("midrst_inputs_zero", mism, 0);
        for (int j = 0; j < 6; j++) begin
            tick();
            check_val("late_done_rv", longint'(result_valid), 0);
            check_val("late_done_busy", longint'(busy), 0);
        end
        check_val("late_done_result", longint'(result), 0);
        $display("txn reset_in_wait: result=%0d result_valid=%0b", result, result_valid);

        run_txn("done_at_expiry", 0, 0, TO, 1'b1, DW'(7), 1'b0);

        pulse_req++;
        tick();
        tick();
        check_val("collect_pulse_rv", longint'(result_valid), 0);
        check_val("collect_pulse_busy", longint'(busy), 0);
        check_val("collect_pulse_in_ready", longint'(in_ready), 1);
        check_val("collect_pulse_result", longint'(result), 7);
        $display("txn done_in_collect: result=%0d result_valid=%0b", result, result_valid);

        fill_seq();
        run_txn("seq_final", 0, 0, NI + 3, 1'b0, '0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got time-limit expected completion");
        $fatal(1, "bench time limit");
    end

endmodule
